// File: rtl/wash_pkg.sv
// wash_pkg: shared state encoding, timer width and rinse-count helper for the wash cycle controller
package wash_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WASH, S_DRAIN, S_SPIN, S_FAULT} state_t;
  localparam int TW = 32;
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return v == 3'd7 ? v : v + 3'd1;
  endfunction
endpackage

// File: rtl/wash_timer.sv
// wash_timer: cycle counter that flags the last cycle before limit is reached
// ports: clk, reset (sync, active-low), clear (sync zero), enable (count), limit (cycles) -> done
import wash_pkg::*;
module wash_timer (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic          done
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign done = enable && cnt == limit - 1'b1;
endmodule

// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: fill/wash/drain/rinse/spin sequencer with fill/drain timeout and heater control
// ports: clk, reset (sync, active-low), start, pause, full, cold, empty in;
//        ready, water_in, wash, drain, speed, fault one-hot phase outs; heat_r relay; rinse_idx passes done
import wash_pkg::*;
module wash_cycle_ctrl #(
  parameter int CLK_HZ  = 50000000,
  parameter int WASH_S  = 4,
  parameter int RINSE_S = 2,
  parameter int SPIN_S  = 2,
  parameter int N_RINSE = 1,
  parameter int TMO_S   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       full,
  input  logic       cold,
  input  logic       empty,
  output logic       ready,
  output logic       water_in,
  output logic       wash,
  output logic       drain,
  output logic       speed,
  output logic       heat_r,
  output logic       fault,
  output logic [2:0] rinse_idx
);
  localparam logic [TW-1:0] WASH_LIM  = TW'(WASH_S * CLK_HZ);
  localparam logic [TW-1:0] RINSE_LIM = TW'(RINSE_S * CLK_HZ);
  localparam logic [TW-1:0] SPIN_LIM  = TW'(SPIN_S * CLK_HZ);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TMO_S * CLK_HZ);
  localparam logic [2:0]    N_R       = 3'(N_RINSE);
  state_t        state, next;
  logic          rinse_f, ph_en, to_en, ph_done, to_done, drained;
  logic [TW-1:0] ph_lim;
  logic [2:0]    idx_nxt;
  assign ph_en   = (state == S_WASH || state == S_SPIN) && !pause;
  assign to_en   = state == S_FILL || state == S_DRAIN;
  assign ph_lim  = state == S_SPIN ? SPIN_LIM : rinse_f ? RINSE_LIM : WASH_LIM;
  assign drained = state == S_DRAIN && empty;
  // only a drain that follows a rinse wash counts as a completed rinse pass
  assign idx_nxt = rinse_f ? sat_inc(rinse_idx) : rinse_idx;
  wash_timer u_ph (.clk(clk), .reset(reset), .clear(state != next), .enable(ph_en), .limit(ph_lim), .done(ph_done));
  wash_timer u_to (.clk(clk), .reset(reset), .clear(state != next), .enable(to_en), .limit(TMO_LIM), .done(to_done));
  always_ff @(posedge clk)
    state <= !reset ? S_IDLE : next;
  always_comb begin
    next = S_IDLE;
    case (state)
      S_IDLE:  next = start ? S_FILL : S_IDLE;
      S_FILL:  next = full ? S_WASH : to_done ? S_FAULT : S_FILL;
      S_WASH:  next = ph_done ? S_DRAIN : S_WASH;
      S_DRAIN: next = empty ? (idx_nxt == N_R ? S_SPIN : S_FILL) : to_done ? S_FAULT : S_DRAIN;
      S_SPIN:  next = ph_done ? S_IDLE : S_SPIN;
      S_FAULT: next = start ? S_IDLE : S_FAULT;
      default: next = S_IDLE;
    endcase
  end
  always_comb begin
    ready    = state == S_IDLE;
    water_in = state == S_FILL;
    wash     = state == S_WASH && !pause;
    drain    = state == S_DRAIN;
    speed    = state == S_SPIN && !pause;
    fault    = state == S_FAULT;
    heat_r   = state == S_WASH && cold && !pause && !ph_done;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      rinse_f   <= 1'b0;
      rinse_idx <= 3'd0;
    end else begin
      rinse_f   <= state == S_IDLE ? 1'b0 : drained ? 1'b1 : rinse_f;
      rinse_idx <= state == S_IDLE && start ? 3'd0 : drained ? idx_nxt : rinse_idx;
    end
endmodule

// File: doc/wash_cycle_ctrl.md
WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock cycles per second.
REQ-002 Parameter WASH_S, default 4, wash phase duration in seconds.
REQ-003 Parameter RINSE_S, default 2, rinse agitation duration in seconds.
REQ-004 Parameter SPIN_S, default 2, spin duration in seconds.
REQ-005 Parameter N_RINSE, default 1, number of rinse passes, legal range 0..7.
REQ-006 Parameter TMO_S, default 10, fill/drain timeout in seconds.
REQ-007 clk  in  1  system clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 start  in  1  begin cycle (level, sampled in IDLE and FAULT).
REQ-010 pause  in  1  freeze timer and motor/heater while high.
REQ-011 full, cold, empty  in  1 each  tank full, water below temperature, tank empty.
REQ-012 ready, water_in, wash, drain, speed  out  1 each  one-hot phase indicators.
REQ-013 heat_r  out  1  heater relay.
REQ-014 fault  out  1  fill or drain timeout occurred.
REQ-015 rinse_idx  out  3  rinse passes completed in the current cycle.

Function
REQ-016 States SHALL be IDLE, FILL, WASH, DRAIN, SPIN, FAULT; outputs are Moore decode of state (IDLE->ready, FILL->water_in, WASH->wash, DRAIN->drain, SPIN->speed, FAULT->fault), exactly one high.
REQ-017 IDLE->FILL on start=1; rinse_idx cleared to 0 on that transition.
REQ-018 FILL->WASH on full=1; FILL->FAULT when timeout counter reaches TMO_S*CLK_HZ-1 with full=0; full wins if both in same cycle.
REQ-019 WASH SHALL last WASH_S*CLK_HZ unpaused cycles when rinse_idx=0 and the first pass is the main wash, else RINSE_S*CLK_HZ unpaused cycles; then ->DRAIN.
REQ-020 Main-wash vs rinse SHALL be tracked by a 1-bit flag set on first DRAIN exit, cleared in IDLE.
REQ-021 DRAIN->next on empty=1: if rinse passes done (rinse_idx==N_RINSE after increment rule) ->SPIN, else ->FILL; DRAIN->FAULT on timeout with empty=0; empty wins if simultaneous.
REQ-022 rinse_idx SHALL increment by 1 on each DRAIN exit that follows a rinse WASH; it saturates at 7 and never wraps.
REQ-023 N_RINSE=0: first DRAIN exit goes directly to SPIN.
REQ-024 SPIN SHALL last SPIN_S*CLK_HZ unpaused cycles, then ->IDLE.
REQ-025 Phase timer: 32-bit, cleared on every state change, increments each cycle in WASH/SPIN with pause=0, holds with pause=1; transition taken in the cycle the timer equals limit-1.
REQ-026 Timeout timer: 32-bit, counts in FILL/DRAIN regardless of pause, cleared on state change.
REQ-027 heat_r = (state==WASH) & cold & ~pause; forced 0 in the terminal cycle of WASH.
REQ-028 pause SHALL force wash and speed outputs low while high in WASH/SPIN (state indicator semantics: motor off); water_in and drain unaffected.
REQ-029 FAULT->IDLE on start=1 (acknowledge); fault output held until then.
REQ-030 Invalid state encoding SHALL return to IDLE next cycle.

Reset
REQ-031 reset=0 at a rising edge SHALL force IDLE, both timers 0, rinse_idx 0, main/rinse flag 0, from any state including mid-phase.
REQ-032 Reset values: ready=1, all other outputs 0, rinse_idx=0.

Structure
REQ-033 State encoding typedef and state constants SHALL live in shared package wash_pkg.
REQ-034 Timers SHALL be one sub-module wash_timer (clear, enable, limit in; done out), instantiated twice.
REQ-035 Cycle-limit constants derived from parameters in wash_cycle_ctrl; no literals in the FSM.

Verification (CLK_HZ=10, WASH_S=2, RINSE_S=1, SPIN_S=1, TMO_S=3, N_RINSE=2)
REQ-036 start, full at cycle 5, empty at 3 cycles into each DRAIN -> sequence FILL,WASH(20),DRAIN,FILL,WASH(10),DRAIN,FILL,WASH(10),DRAIN,SPIN(10),IDLE; rinse_idx ends 2.
REQ-037 start, full never asserted -> FAULT after 30 cycles in FILL, fault=1; start -> IDLE.
REQ-038 pause high 7 cycles mid-WASH -> WASH lasts 27 cycles, wash and heat_r low during pause.
REQ-039 cold=1 throughout WASH -> heat_r high for 19 cycles, low on terminal cycle.
REQ-040 reset low during SPIN -> next edge IDLE, ready=1, rinse_idx=0; new start runs full cycle.
REQ-041 N_RINSE=0 build -> DRAIN after main wash goes directly to SPIN.
